// File: rtl/fsmind_pkg.sv
// Shared types and constants for the FSMIND exposure-handshake initiator.
package fsmind_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    EXPOSE  = 3'd2,
    ACK0    = 3'd3,
    RELEASE = 3'd4,
    GAP     = 3'd5,
    ERR     = 3'd6
  } state_t;

  localparam int unsigned TIMEOUT_CYC_DEF = 1048576;

endpackage

// File: rtl/fsmind_seq_ctrl_sync_bit.sv
// Multi-stage flop chain bringing one asynchronous chip pin into the clk domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_reg <= '0;
    else        chain_reg <= {chain_reg[STAGES-2:0], d};
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/fsmind_seq_ctrl.sv
// FPGA-side initiator for the FSMIND1/FSMIND0 exposure handshake: one
// four-phase request/acknowledge cycle per pattern, with gap, abort and watchdog.
module fsmind_seq_ctrl
  import fsmind_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [CNT_W-1:0] exp_cyc,
  input  logic [CNT_W-1:0] gap_cyc,
  output logic             FSMIND1,
  input  logic             FSMIND1ACK,
  input  logic             FSMIND0,
  output logic             FSMIND0ACK,
  output logic             busy,
  output logic             exposing,
  output logic [CNT_W-1:0] pat_idx,
  output logic             done,
  output logic             timeout_err,
  input  logic             clr_err
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] num_reg, num_next;
  logic [CNT_W-1:0] exp_reg, exp_next;
  logic [CNT_W-1:0] gap_reg, gap_next;
  logic [CNT_W-1:0] pat_reg, pat_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] wd_reg, wd_next;
  logic             abort_reg, abort_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             ack1_s, ind0_s;
  logic             abort_req, exp_met, last_pat, wd_run, wd_expired;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack1 (.clk(clk), .rst_n(rst_n), .d(FSMIND1ACK), .q(ack1_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ind0 (.clk(clk), .rst_n(rst_n), .d(FSMIND0),    .q(ind0_s));

  // exp_reg holds the effective exposure (never 0), so exp_reg-1 cannot underflow.
  assign abort_req  = abort | abort_reg;
  assign exp_met    = (cnt_reg >= (exp_reg - ONE));
  assign last_pat   = (pat_reg == (num_reg - ONE));
  assign wd_run     = (state_reg == REQ) || (state_reg == RELEASE) ||
                      ((state_reg == EXPOSE) && exp_met);
  assign wd_expired = wd_run && (wd_reg == WD_LAST);

  always_comb begin
    state_next = state_reg;
    num_next   = num_reg;
    exp_next   = exp_reg;
    gap_next   = gap_reg;
    pat_next   = pat_reg;
    cnt_next   = cnt_reg;
    wd_next    = wd_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    FSMIND1    = 1'b0;
    FSMIND0ACK = 1'b0;
    exposing   = 1'b0;

    if (clr_err) err_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          if (num_pat == '0) begin
            done_next = 1'b1;
          end else begin
            num_next   = num_pat;
            exp_next   = (exp_cyc == '0) ? ONE : exp_cyc;
            gap_next   = gap_cyc;
            pat_next   = '0;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        FSMIND1 = 1'b1;
        if (wd_expired)     state_next = ERR;
        else if (abort_req) state_next = RELEASE;
        else if (ack1_s)    state_next = EXPOSE;
      end
      EXPOSE: begin
        FSMIND1  = 1'b1;
        exposing = 1'b1;
        if (wd_expired)             state_next = ERR;
        else if (abort_req)         state_next = RELEASE;
        else if (exp_met && ind0_s) state_next = ACK0;
      end
      ACK0: begin
        FSMIND0ACK = 1'b1;
        state_next = RELEASE;
      end
      RELEASE: begin
        // Acknowledge stays up until the chip has returned both pins to idle.
        FSMIND0ACK = ack1_s | ind0_s;
        if (wd_expired) begin
          state_next = ERR;
        end else if (!ack1_s && !ind0_s) begin
          if (last_pat || abort_req) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else if (gap_reg == '0) begin
            pat_next   = pat_reg + ONE;
            state_next = REQ;
          end else begin
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (abort_req) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == (gap_reg - ONE)) begin
          pat_next   = pat_reg + ONE;
          state_next = REQ;
        end
      end
      ERR: begin
        if (clr_err) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if ((state_next == ERR) && (state_reg != ERR)) err_next = 1'b1;

    // Exposure/gap counter and watchdog both restart on every state change.
    if (state_next != state_reg) begin
      cnt_next = '0;
      wd_next  = '0;
    end else begin
      if ((state_reg == EXPOSE) || (state_reg == GAP)) cnt_next = cnt_reg + ONE;
      if (wd_run) wd_next = wd_reg + ONE;
    end

    abort_next = (state_next != IDLE) && abort_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      num_reg   <= '0;
      exp_reg   <= '0;
      gap_reg   <= '0;
      pat_reg   <= '0;
      cnt_reg   <= '0;
      wd_reg    <= '0;
      abort_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      num_reg   <= num_next;
      exp_reg   <= exp_next;
      gap_reg   <= gap_next;
      pat_reg   <= pat_next;
      cnt_reg   <= cnt_next;
      wd_reg    <= wd_next;
      abort_reg <= abort_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign pat_idx     = pat_reg;
  assign done        = done_reg;
  assign timeout_err = err_reg;

endmodule

// File: tb/tb_fsmind_seq_ctrl.sv
// Self-checking bench: behavioural chip responder, event monitor and per-scenario tests.
module tb_fsmind_seq_ctrl;

  localparam int SYNC = 2;
  localparam int TO   = 64;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, clr_err = 1'b0;
  logic [31:0] num_pat = '0, exp_cyc = '0, gap_cyc = '0;
  logic        FSMIND1, FSMIND0ACK, busy, exposing, done, timeout_err;
  logic [31:0] pat_idx;
  logic        chip_ack1 = 1'b0, chip_ind0 = 1'b0;

  int n_tests = 0, n_fail = 0;

  fsmind_seq_ctrl #(.CNT_W(32), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_pat(num_pat), .exp_cyc(exp_cyc), .gap_cyc(gap_cyc),
    .FSMIND1(FSMIND1), .FSMIND1ACK(chip_ack1), .FSMIND0(chip_ind0), .FSMIND0ACK(FSMIND0ACK),
    .busy(busy), .exposing(exposing), .pat_idx(pat_idx), .done(done),
    .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Chip responder: acks ack_dly cycles after FSMIND1 rises, raises IND0
  // ind0_dly cycles after that, and drops both once FSMIND1 falls.
  bit chip_en  = 1'b1;
  int ack_dly  = 10;
  int ind0_dly = 20;
  int ccnt     = 0;
  always @(posedge clk) begin
    if (!FSMIND1) begin
      ccnt <= 0; chip_ack1 <= 1'b0; chip_ind0 <= 1'b0;
    end else begin
      ccnt      <= ccnt + 1;
      chip_ack1 <= chip_en && (ccnt + 1 >= ack_dly);
      chip_ind0 <= chip_en && (ccnt + 1 >= ack_dly + ind0_dly);
    end
  end

  // Monitor: timestamps of edges, sampled on the falling clock edge.
  int cyc = 0;
  int q_ind1_rise[$], q_pat[$], q_ack_rise[$], q_ind0_rise[$];
  int q_exp_rise[$], q_exp_len[$], q_ack0_rise[$], q_ack0_fall[$];
  int done_cnt = 0, busy_cyc = 0, last_start = 0, last_done = 0;
  int err_rise = 0, abort_rise = 0, last_ind1_fall = 0;
  logic p_ind1 = 0, p_exp = 0, p_ack0 = 0, p_ack1c = 0, p_ind0c = 0, p_err = 0, p_abort = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (FSMIND1 && !p_ind1) begin q_ind1_rise.push_back(cyc); q_pat.push_back(int'(pat_idx)); end
    if (!FSMIND1 && p_ind1) last_ind1_fall <= cyc;
    if (chip_ack1 && !p_ack1c) q_ack_rise.push_back(cyc);
    if (chip_ind0 && !p_ind0c) q_ind0_rise.push_back(cyc);
    if (exposing && !p_exp) q_exp_rise.push_back(cyc);
    if (!exposing && p_exp) q_exp_len.push_back(cyc - q_exp_rise[$]);
    if (FSMIND0ACK && !p_ack0) q_ack0_rise.push_back(cyc);
    if (!FSMIND0ACK && p_ack0) q_ack0_fall.push_back(cyc);
    if (done) begin done_cnt <= done_cnt + 1; last_done <= cyc; end
    if (busy) busy_cyc <= busy_cyc + 1;
    if (start) last_start <= cyc;
    if (timeout_err && !p_err) err_rise <= cyc;
    if (abort && !p_abort) abort_rise <= cyc;
    p_ind1 <= FSMIND1; p_exp <= exposing; p_ack0 <= FSMIND0ACK;
    p_ack1c <= chip_ack1; p_ind0c <= chip_ind0; p_err <= timeout_err; p_abort <= abort;
  end

  task automatic start_seq(input int n, input int e, input int g);
    @(posedge clk); #1;
    num_pat = n; exp_cyc = e; gap_cyc = g; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      if (done_cnt > d0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if ({FSMIND1, FSMIND0ACK, busy, exposing, done, timeout_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 000000", {FSMIND1, FSMIND0ACK, busy, exposing, done, timeout_err}); end
    n_tests++; if (pat_idx !== 32'd0) begin
      n_fail++; $display("FAIL reset_pat_idx: got %0d expected 0", pat_idx); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || FSMIND1 !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b ind1=%b expected 0 0", busy, FSMIND1); end
    $display("[TB] reset checked");
  endtask

  // Iteration 0 is the nominal run (3 patterns, exp 20, gap 5, ack 10, IND0 at 30);
  // the rest draw random configurations and chip timings.
  task automatic test_sequences;
    for (int s = 0; s < 7; s++) begin
      int n, e, g, eff, b, bp, d0, got_n, want_len, seen;
      bit ok;
      if (s == 0) begin
        n = 3; e = 20; g = 5; ack_dly = 10; ind0_dly = 20;
      end else begin
        n = $urandom_range(1, 4); e = $urandom_range(0, 30); g = $urandom_range(0, 8);
        ack_dly = $urandom_range(1, 10); ind0_dly = $urandom_range(1, 40);
      end
      chip_en = 1'b1;
      eff = (e == 0) ? 1 : e;
      b = q_exp_rise.size(); bp = q_ind1_rise.size(); d0 = done_cnt;
      start_seq(n, e, g);
      wait_done(d0, 3000, ok);
      @(negedge clk);
      $display("[TB] seq %0d: n=%0d exp=%0d gap=%0d ack=%0d ind0=%0d", s, n, e, g, ack_dly, ind0_dly);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL seq%0d_done_wait: got no done expected done", s); end
      got_n = q_ind1_rise.size() - bp;
      n_tests++; if (got_n != n) begin n_fail++; $display("FAIL seq%0d_ind1_pulses: got %0d expected %0d", s, got_n, n); end
      n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL seq%0d_done_count: got %0d expected 1", s, done_cnt - d0); end
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL seq%0d_timeout_err: got %b expected 0", s, timeout_err); end
      if (got_n == n && q_exp_len.size() - b == n && q_ack0_fall.size() >= b + n) begin
        n_tests++; if (q_ind1_rise[bp] - last_start != 1) begin
          n_fail++; $display("FAIL seq%0d_req_latency: got %0d expected 1", s, q_ind1_rise[bp] - last_start); end
        for (int j = 0; j < n; j++) begin
          n_tests++; if (q_pat[bp + j] != j) begin
            n_fail++; $display("FAIL seq%0d_pat_idx[%0d]: got %0d expected %0d", s, j, q_pat[bp + j], j); end
          n_tests++; if (q_exp_rise[b + j] != q_ack_rise[b + j] + SYNC + 1) begin
            n_fail++; $display("FAIL seq%0d_expose_start[%0d]: got %0d expected %0d", s, j, q_exp_rise[b + j], q_ack_rise[b + j] + SYNC + 1); end
          // Exposure ends once the minimum time has elapsed and IND0 has been seen.
          seen = q_ind0_rise[b + j] + SYNC - q_exp_rise[b + j] + 1;
          want_len = (seen > eff) ? seen : eff;
          n_tests++; if (q_exp_len[b + j] != want_len) begin
            n_fail++; $display("FAIL seq%0d_expose_len[%0d]: got %0d expected %0d", s, j, q_exp_len[b + j], want_len); end
          if (j > 0) begin
            n_tests++; if (q_ind1_rise[bp + j] - q_ack0_fall[b + j - 1] != g + 1) begin
              n_fail++; $display("FAIL seq%0d_gap[%0d]: got %0d expected %0d", s, j, q_ind1_rise[bp + j] - q_ack0_fall[b + j - 1], g + 1); end
          end
        end
      end
      repeat (5) @(posedge clk);
    end
  endtask

  task automatic test_early_ind0;
    int b, d0, gap_ack;
    bit ok;
    chip_en = 1'b1; ack_dly = 10; ind0_dly = 5;
    b = q_exp_rise.size(); d0 = done_cnt;
    start_seq(1, 100, 0);
    wait_done(d0, 1000, ok);
    @(negedge clk);
    $display("[TB] early ind0: exp=100 ind0 5 cycles after ack");
    n_tests++; if (!ok) begin n_fail++; $display("FAIL early_done_wait: got no done expected done"); end
    if (q_exp_len.size() > b && q_ack0_rise.size() > b) begin
      gap_ack = q_ack0_rise[b] - (q_ack_rise[b] + SYNC);
      n_tests++; if (gap_ack < 100) begin n_fail++; $display("FAIL early_ack0_latency: got %0d expected >=100", gap_ack); end
      n_tests++; if (q_exp_len[b] != 100) begin n_fail++; $display("FAIL early_expose_len: got %0d expected 100", q_exp_len[b]); end
    end else begin
      n_tests++; n_fail++; $display("FAIL early_events: got %0d exposures expected 1", q_exp_len.size() - b);
    end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_zero_patterns;
    int d0, i0, b0;
    d0 = done_cnt; i0 = q_ind1_rise.size(); b0 = busy_cyc;
    start_seq(0, 10, 3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("[TB] num_pat=0 sequence");
    n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt - d0); end
    n_tests++; if (last_done - last_start != 1) begin n_fail++; $display("FAIL zero_done_latency: got %0d expected 1", last_done - last_start); end
    n_tests++; if (q_ind1_rise.size() != i0) begin n_fail++; $display("FAIL zero_ind1_toggle: got %0d expected 0", q_ind1_rise.size() - i0); end
    n_tests++; if (busy_cyc != b0) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_cyc - b0); end
  endtask

  task automatic test_timeout;
    int d0, i0, i1;
    bit ok, hit;
    chip_en = 1'b0;
    d0 = done_cnt; i0 = q_ind1_rise.size();
    start_seq(2, 10, 0);
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (timeout_err) begin hit = 1'b1; break; end
    end
    @(negedge clk);
    $display("[TB] timeout: chip never acks");
    n_tests++; if (!hit) begin n_fail++; $display("FAIL timeout_flag: got 0 expected 1"); end
    if (q_ind1_rise.size() > i0) begin
      n_tests++; if (err_rise - q_ind1_rise[i0] != TO) begin
        n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", err_rise - q_ind1_rise[i0], TO); end
    end
    n_tests++; if ({FSMIND1, FSMIND0ACK, busy} !== 3'b001) begin
      n_fail++; $display("FAIL err_outputs: got ind1/ack0/busy=%b expected 001", {FSMIND1, FSMIND0ACK, busy}); end
    n_tests++; if (done_cnt != d0) begin n_fail++; $display("FAIL err_no_done: got %0d done expected 0", done_cnt - d0); end
    // clr_err and start together: clr_err wins, start is dropped.
    i1 = q_ind1_rise.size();
    @(posedge clk); #1; clr_err = 1'b1; start = 1'b1; num_pat = 1;
    @(posedge clk); #1; clr_err = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if ({busy, timeout_err} !== 2'b00) begin
      n_fail++; $display("FAIL clr_err_idle: got busy/err=%b expected 00", {busy, timeout_err}); end
    n_tests++; if (q_ind1_rise.size() != i1) begin
      n_fail++; $display("FAIL clr_err_start_ignored: got %0d requests expected 0", q_ind1_rise.size() - i1); end
    chip_en = 1'b1; ack_dly = 3; ind0_dly = 4;
    d0 = done_cnt; i1 = q_ind1_rise.size();
    start_seq(1, 4, 0);
    wait_done(d0, 500, ok);
    @(negedge clk);
    n_tests++; if (!ok || q_ind1_rise.size() - i1 != 1) begin
      n_fail++; $display("FAIL restart_after_err: got done=%0d requests=%0d expected 1 1", ok, q_ind1_rise.size() - i1); end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_abort;
    int d0, i0;
    bit ok, hit;
    chip_en = 1'b1; ack_dly = 5; ind0_dly = 60;
    d0 = done_cnt; i0 = q_ind1_rise.size();
    start_seq(4, 40, 3);
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (pat_idx == 32'd1 && exposing) begin hit = 1'b1; break; end
    end
    repeat (5) @(posedge clk);
    #1; abort = 1'b1;
    wait_done(d0, 500, ok);
    @(negedge clk);
    $display("[TB] abort during pattern 1 of 4");
    n_tests++; if (!hit || !ok) begin n_fail++; $display("FAIL abort_flow: got reached=%0d done=%0d expected 1 1", hit, ok); end
    n_tests++; if (last_ind1_fall - abort_rise != 1) begin
      n_fail++; $display("FAIL abort_ind1_drop: got %0d expected 1", last_ind1_fall - abort_rise); end
    n_tests++; if (pat_idx !== 32'd1) begin n_fail++; $display("FAIL abort_pat_idx: got %0d expected 1", pat_idx); end
    n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL abort_done_count: got %0d expected 1", done_cnt - d0); end
    abort = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_tests++; if (q_ind1_rise.size() - i0 != 2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_more_req: got requests=%0d busy=%b expected 2 0", q_ind1_rise.size() - i0, busy); end
  endtask

  task automatic test_reset_mid;
    int d0, i0;
    bit ok, hit;
    chip_en = 1'b1; ack_dly = 4; ind0_dly = 10;
    start_seq(3, 10, 2);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (FSMIND0ACK) begin hit = 1'b1; break; end
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] reset pulsed during release");
    n_tests++; if (!hit || {FSMIND1, FSMIND0ACK, busy, exposing, done, timeout_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %b reached=%0d expected 000000 1", {FSMIND1, FSMIND0ACK, busy, exposing, done, timeout_err}, hit); end
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    d0 = done_cnt; i0 = q_ind1_rise.size();
    start_seq(2, 8, 1);
    wait_done(d0, 1000, ok);
    @(negedge clk);
    n_tests++; if (!ok || q_ind1_rise.size() - i0 != 2) begin
      n_fail++; $display("FAIL post_reset_seq: got done=%0d requests=%0d expected 1 2", ok, q_ind1_rise.size() - i0); end
    if (q_pat.size() >= i0 + 2) begin
      n_tests++; if (q_pat[i0] != 0 || q_pat[i0 + 1] != 1) begin
        n_fail++; $display("FAIL post_reset_pat_idx: got %0d,%0d expected 0,1", q_pat[i0], q_pat[i0 + 1]); end
    end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL post_reset_err: got %b expected 0", timeout_err); end
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_early_ind0();
    test_zero_patterns();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fsmind_seq_ctrl.md
Name: fsmind_seq_ctrl

Overview:
- FPGA-side initiator for the imager FSMIND exposure handshake; the sensor chip is the responder.
- For each of num_pat patterns it raises FSMIND1, waits for the chip's FSMIND1ACK, times the exposure, and acknowledges the chip's FSMIND0 with FSMIND0ACK.
- It then releases both channels four-phase and waits a programmable gap before the next pattern.
- Sits in Reveal_top between the okWireIn config registers (num_pat, exposure, projector trigger) and the chip pins.

Parameters:
- CNT_W, 32, width of num_pat, exp_cyc, gap_cyc and the internal counters.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous chip input (minimum 2).
- TIMEOUT_CYC, 1048576, maximum cycles spent in any wait state before error.

Ports:
- clk  in  1  system clock; all logic is on this one clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a sequence.
- abort  in  1  level input; requests an orderly release.
- num_pat  in  CNT_W  patterns per sequence; sampled at start.
- exp_cyc  in  CNT_W  minimum exposure cycles counted from FSMIND1ACK; sampled at start.
- gap_cyc  in  CNT_W  idle cycles between patterns; sampled at start.
- FSMIND1  out  1  exposure request to chip.
- FSMIND1ACK  in  1  chip acknowledges the request (asynchronous).
- FSMIND0  in  1  chip subframe-ready indication (asynchronous).
- FSMIND0ACK  out  1  FPGA acknowledges FSMIND0.
- busy  out  1  high while not IDLE.
- exposing  out  1  high while in EXPOSE; used as the projector-trigger qualifier.
- pat_idx  out  CNT_W  index of the current pattern, 0-based.
- done  out  1  one-cycle pulse when a sequence ends normally or by abort.
- timeout_err  out  1  sticky error flag.
- clr_err  in  1  pulse; clears timeout_err and returns the block from ERR to IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, synchronizers 0.
- Synchronization: FSMIND1ACK and FSMIND0 pass through SYNC_STAGES flops before use. All latencies below are counted from the synchronized signal (ack1_s, ind0_s).
- IDLE:
  - start with num_pat==0 -> done pulses the next cycle, state stays IDLE.
  - start with num_pat!=0 -> latch num_pat, exp_cyc and gap_cyc; pat_idx=0; go to REQ. FSMIND1 goes high the cycle after start.
  - start outside IDLE is ignored.
- REQ: FSMIND1=1. When ack1_s=1 -> EXPOSE and clear the exposure counter.
- EXPOSE: FSMIND1=1, exposing=1, the exposure counter increments each cycle. When exposure counter >= exp_cyc-1 and ind0_s=1 -> ACK0. An exp_cyc of 0 is treated as 1.
- ACK0: FSMIND0ACK=1, FSMIND1=0, go to RELEASE on the next cycle.
- RELEASE: FSMIND1=0, FSMIND0ACK=1. When ack1_s=0 and ind0_s=0 -> drop FSMIND0ACK the same cycle.
  - If pat_idx==num_pat-1 or abort is pending -> done pulse, go to IDLE.
  - Otherwise -> GAP.
- GAP: all outputs low, count gap_cyc cycles (0 means no wait), then pat_idx+1 and go to REQ.
- abort:
  - In REQ or EXPOSE -> go directly to RELEASE with FSMIND1 dropped. If the chip has already asserted IND0, it is still acknowledged in RELEASE.
  - In GAP -> done pulse, go to IDLE.
  - The abort request is latched until IDLE is reached.
- Timeout: the watchdog resets on every state change. After TIMEOUT_CYC cycles in REQ, EXPOSE (past exp_cyc) or RELEASE -> go to ERR.
  - On entry to ERR: drive FSMIND1=0 and FSMIND0ACK=0, set timeout_err=1, busy=1, no done pulse.
  - ERR exits to IDLE only on clr_err.
  - clr_err in any other state only clears the flag.
- Simultaneous events: abort and timeout in the same cycle -> timeout wins. start and clr_err in the same cycle in ERR -> clr_err acts and start is ignored.
- Counters: pat_idx never wraps, because the sequence ends at num_pat-1. All comparisons are unsigned, CNT_W wide.
- Reset mid-operation: outputs drop asynchronously to 0. The chip sees FSMIND1 fall and must return its signals to idle; the next start re-handshakes.

Decomposition:
- Package fsmind_pkg: state enum (IDLE, REQ, EXPOSE, ACK0, RELEASE, GAP, ERR) and the default TIMEOUT_CYC constant.
- One sub-module, sync_bit: a parameterized SYNC_STAGES flop chain with asynchronous reset to 0, instantiated once per chip input.

Test Plan:
- Normal run: num_pat=3, exp_cyc=20, gap_cyc=5; chip model acks IND1 after 10 cycles and raises IND0 after 30 cycles, dropping both when IND1 falls -> exactly 3 IND1 pulses, pat_idx 0,1,2, done pulses once, timeout_err=0.
- Early IND0: exp_cyc=100, IND0 arrives 5 cycles after ack -> FSMIND0ACK rises no earlier than 100 cycles after ack1_s; exposing is high for at least 100 cycles.
- num_pat=0 -> done pulses 1 cycle after start, FSMIND1 never toggles, busy stays 0.
- Chip never acks, TIMEOUT_CYC=64 -> entry to ERR 64 cycles after entering REQ, FSMIND1=0, timeout_err=1; clr_err -> IDLE; a new start succeeds.
- abort asserted mid-EXPOSE on pattern 1 of 4 -> FSMIND1 drops the next cycle, release completes, done pulses, pat_idx=1, no pattern 2 request.
- rst_n pulsed low during RELEASE -> all outputs 0 immediately; after reset, start runs a clean full sequence.
